// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsk_pkg
//  Brief    : Shared types and the tone-map helper for the MFSK modulator.
//  Revision : 1.0  initial release
// ============================================================================
package fsk_pkg;

  // Modulator control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Phase increment of symbol sym: the all-ones symbol sits on f_base and
  // each step down in symbol value moves one f_step higher in frequency.
  function automatic int unsigned tone_incr(input int unsigned sym,
                                            input int unsigned f_base,
                                            input int unsigned f_step,
                                            input int unsigned m);
    return f_base + (m - 1 - sym) * f_step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsk_sine_lut.sv
`default_nettype none
// ============================================================================
//  Module   : fsk_sine_lut
//  Brief    : Full-wave signed sine table with a one-cycle registered read.
//  Revision : 1.0  initial release
// ============================================================================
module fsk_sine_lut #(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [OUT_W-1:0]  data
);

  localparam int  DEPTH = 2 ** ADDR_W;
  localparam real PEAK  = real'(2 ** (OUT_W - 1) - 1);
  localparam real PI    = 3.14159265358979323846;

  logic signed [OUT_W-1:0] rom [DEPTH];

  // Each entry is a rounded constant computed at elaboration time
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real SV  = PEAK * $sin(2.0 * PI * real'(i) / real'(DEPTH));
    localparam int  VAL = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(-SV + 0.5);
    assign rom[i] = OUT_W'(VAL);
  end

  // Registered table read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= rom[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mfsk_mod.sv
`default_nettype none
// ============================================================================
//  Module   : mfsk_mod
//  Brief    : Continuous-phase M-ary FSK modulator. Bytes are serialised LSB
//             first into BITS_PER_SYM-bit symbols on a free-running SPS grid;
//             a phase accumulator drives a sine table every clock.
//  Revision : 1.0  initial release
// ============================================================================
module mfsk_mod
  import fsk_pkg::*;
#(
  parameter int                  BITS_PER_SYM = 1,
  parameter int                  SPS          = 64,
  parameter int                  PHASE_W      = 16,
  parameter int                  LUT_ADDR_W   = 10,
  parameter int                  OUT_W        = 14,
  parameter logic [PHASE_W-1:0]  F_BASE       = 16'd18432,
  parameter logic [PHASE_W-1:0]  F_STEP       = 16'd4096
) (
  input  logic                    clk_sample,
  input  logic                    rst,
  input  logic [7:0]              s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    busy,
  output logic                    sym_strobe,
  output logic                    data_valid,
  output logic signed [OUT_W-1:0] data_out
);

  localparam int unsigned M      = 2 ** BITS_PER_SYM;
  localparam int          NSYM   = 8 / BITS_PER_SYM;
  localparam int          CNT_W  = $clog2(SPS);
  localparam int          LEFT_W = $clog2(NSYM + 1);
  localparam logic [PHASE_W-1:0] INC_IDLE =
    PHASE_W'(tone_incr(M - 1, 32'(F_BASE), 32'(F_STEP), M));

  // The highest tone must stay below Nyquist, and bytes must split evenly
  if (32'(F_BASE) + (M - 1) * 32'(F_STEP) >= 2 ** (PHASE_W - 1)) begin : g_bad_tone
    $fatal(1, "mfsk_mod: highest tone increment reaches Nyquist");
  end
  if (8 % BITS_PER_SYM != 0) begin : g_bad_bps
    $fatal(1, "mfsk_mod: BITS_PER_SYM must divide 8");
  end
  if (SPS < 2) begin : g_bad_sps
    $fatal(1, "mfsk_mod: SPS must be at least 2");
  end

  state_t               state, state_next;
  logic [CNT_W-1:0]     sym_cnt;
  logic                 boundary;
  logic [7:0]           hold;
  logic                 hold_full;
  logic                 accept;
  logic [7:0]           shift;
  logic [LEFT_W-1:0]    sym_left;
  logic [PHASE_W-1:0]   inc_reg;
  logic [PHASE_W-1:0]   phase_acc;
  logic                 load;
  logic                 step;
  logic                 valid_pipe;

  assign boundary = (sym_cnt == CNT_W'(SPS - 1));
  assign accept   = s_tvalid && s_tready;
  assign busy     = (state == SEND) || hold_full;

  // Free-running symbol grid counter
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      sym_cnt <= '0;
    end else if (boundary) begin
      sym_cnt <= '0;
    end else begin
      sym_cnt <= sym_cnt + 1'b1;
    end
  end

  // One-byte holding register; ready mirrors the next empty state
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      s_tready  <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= s_tdata;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      s_tready <= !(accept || (hold_full && !load));
    end
  end

  // State register
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave SEND only when the last symbol ends with nothing held
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (boundary && hold_full) state_next = SEND;
      SEND: if (boundary && (sym_left == LEFT_W'(1)) && !hold_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: load a fresh byte, or step to the next symbol of this one
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: load = boundary && hold_full;
      SEND: begin
        if (boundary) begin
          if (sym_left == LEFT_W'(1)) load = hold_full;
          else                        step = 1'b1;
        end
      end
      default: begin
        load = 1'b0;
        step = 1'b0;
      end
    endcase
  end

  // Symbol shifter and tone selection; the first symbol plays straight from hold
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      sym_left   <= '0;
      inc_reg    <= INC_IDLE;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= load || step;
      if (load) begin
        inc_reg  <= PHASE_W'(tone_incr(32'(hold[BITS_PER_SYM-1:0]),
                                       32'(F_BASE), 32'(F_STEP), M));
        shift    <= hold >> BITS_PER_SYM;
        sym_left <= LEFT_W'(NSYM);
      end else if (step) begin
        inc_reg  <= PHASE_W'(tone_incr(32'(shift[BITS_PER_SYM-1:0]),
                                       32'(F_BASE), 32'(F_STEP), M));
        shift    <= shift >> BITS_PER_SYM;
        sym_left <= sym_left - 1'b1;
      end else if (boundary && (state == SEND)) begin
        inc_reg  <= INC_IDLE;
        sym_left <= '0;
      end
    end
  end

  // Phase accumulator, never cleared at boundaries so the phase stays continuous
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      phase_acc <= '0;
    end else begin
      phase_acc <= phase_acc + inc_reg;
    end
  end

  // Valid follows the two-stage accumulator/table pipeline
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      valid_pipe <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      valid_pipe <= 1'b1;
      data_valid <= valid_pipe;
    end
  end

  fsk_sine_lut #(
    .ADDR_W (LUT_ADDR_W),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk  (clk_sample),
    .rst  (rst),
    .addr (phase_acc[PHASE_W-1 -: LUT_ADDR_W]),
    .data (data_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_mfsk_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfsk_mod
//  Brief    : Scoreboard bench for mfsk_mod (binary and four-ary instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mfsk_mod;

  localparam int SPS   = 64;
  localparam int SPS4  = 16;
  localparam int IDLEI = 18432;
  localparam int STEPI = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]         s_tdata  = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tready, busy, sym_strobe, data_valid;
  logic signed [13:0] data_out;

  logic [7:0]         s4_tdata  = '0;
  logic               s4_tvalid = 1'b0;
  logic               s4_tready, busy4, strobe4, dv4;
  logic signed [13:0] data4;

  always #5 clk = ~clk;

  mfsk_mod dut (
    .clk_sample (clk),  .rst (rst),
    .s_tdata (s_tdata), .s_tvalid (s_tvalid), .s_tready (s_tready),
    .busy (busy), .sym_strobe (sym_strobe),
    .data_valid (data_valid), .data_out (data_out)
  );

  mfsk_mod #(.BITS_PER_SYM(2), .SPS(SPS4)) dut4 (
    .clk_sample (clk),  .rst (rst),
    .s_tdata (s4_tdata), .s_tvalid (s4_tvalid), .s_tready (s4_tready),
    .busy (busy4), .sym_strobe (strobe4),
    .data_valid (dv4), .data_out (data4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sine_ref(input int a);
    real s;
    s = 8191.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  typedef struct {
    int inc;
    bit first;
    int acc;
  } sb_t;

  sb_t sb[$];
  int  sb4[$];

  // ---------------- binary-instance model and monitor ----------------
  int gcyc = 0, rel = 0, phase_m = 0, phase_prev = 0, exp_inc = IDLEI, rem = 0;
  bit sym_active = 0;

  always @(negedge clk) begin
    sb_t e;
    gcyc++;
    if (rst) begin
      check_eq("rst_data_out", int'(data_out), 0);
      check_eq("rst_data_valid", int'(data_valid), 0);
      check_eq("rst_tready", int'(s_tready), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_strobe", int'(sym_strobe), 0);
      check_eq("rst_phase", int'(dut.phase_acc), 0);
      sb.delete();
      rel = 0; phase_m = 0; phase_prev = 0; exp_inc = IDLEI; rem = 0; sym_active = 0;
    end else begin
      rel++;
      phase_prev = phase_m;
      phase_m    = (phase_m + exp_inc) % 65536;
      check_eq("phase_acc", int'(dut.phase_acc), phase_m);
      check_eq("data_out", int'(data_out), sine_ref(phase_prev / 64));
      check_eq("data_valid", int'(data_valid), (rel >= 2) ? 1 : 0);
      if (rel == 1) check_eq("tready_after_reset", int'(s_tready), 1);
      if (sym_strobe) begin
        if (sb.size() == 0) begin
          check_eq("strobe_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          if (sym_active) check_eq("sym_len", rem, 0);
          else if (e.first)
            check_eq("latency_in_range",
                     ((gcyc - e.acc) >= 1 && (gcyc - e.acc) <= SPS) ? 1 : 0, 1);
          exp_inc = e.inc; rem = SPS - 1; sym_active = 1;
        end
      end else if (sym_active) begin
        if (rem > 0) begin
          rem--;
        end else begin
          sym_active = 0;
          exp_inc    = IDLEI;
          if (sb.size() > 0) check_eq("sym_missing", sb.size(), 0);
        end
      end
      check_eq("inc_reg", int'(dut.inc_reg), exp_inc);
      check_eq("busy", int'(busy), (sym_active || sb.size() > 0) ? 1 : 0);
    end
  end

  // ---------------- four-ary-instance monitor ----------------
  int cyc4 = 0, last4 = 0;
  bit have_last4 = 0;

  always @(negedge clk) begin
    int e4;
    cyc4++;
    if (rst) begin
      sb4.delete();
      have_last4 = 0;
    end else if (strobe4) begin
      if (sb4.size() == 0) begin
        check_eq("b4_strobe_unexpected", 1, 0);
      end else begin
        e4 = sb4.pop_front();
        check_eq("b4_inc", int'(dut4.inc_reg), e4);
        if (have_last4) check_eq("b4_gap", cyc4 - last4, SPS4);
        last4      = cyc4;
        have_last4 = (sb4.size() > 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offers one byte (valid left high on return); expectations pushed on accept
  task automatic send_byte(input logic [7:0] b);
    bit  done = 0;
    sb_t e;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (s_tready) begin
        for (int k = 0; k < 8; k++) begin
          e.inc   = IDLEI + (1 - int'(b[k])) * STEPI;
          e.first = (k == 0);
          e.acc   = gcyc + 1;
          sb.push_back(e);
        end
        done = 1;
      end
      step();
    end
    if (!done) check_eq("accept_timeout", 0, 1);
    else       check_eq("tready_drop", int'(s_tready), 0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((busy || sb.size() > 0) && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("idle_reached", (!busy && sb.size() == 0) ? 1 : 0, 1);
  endtask

  initial begin
    logic [7:0] b4;
    bit         done4;
    int         n;

    repeat (3) step();
    rst = 1'b0;

    // Idle tone after reset
    repeat (200) step();
    check_eq("idle_busy", int'(busy), 0);

    // Single binary byte
    send_byte(8'hA5);
    s_tvalid = 1'b0;
    wait_idle(2000);
    repeat (70) step();

    // Back-to-back bytes with valid held
    send_byte(8'h00);
    send_byte(8'hFF);
    s_tvalid = 1'b0;
    wait_idle(3000);
    repeat (10) step();

    // Four-ary byte 0x1B -> symbols 3,2,1,0
    b4    = 8'h1B;
    done4 = 0;
    s4_tdata  = b4;
    s4_tvalid = 1'b1;
    for (int i = 0; i < 500 && !done4; i++) begin
      if (s4_tready) begin
        for (int k = 0; k < 4; k++) sb4.push_back(IDLEI + (3 - int'(b4[2*k +: 2])) * STEPI);
        done4 = 1;
      end
      step();
    end
    s4_tvalid = 1'b0;
    check_eq("b4_accepted", int'(done4), 1);
    n = 0;
    while ((busy4 || sb4.size() > 0) && n < 500) begin
      step();
      n++;
    end
    check_eq("b4_idle", (!busy4 && sb4.size() == 0) ? 1 : 0, 1);
    step();
    check_eq("b4_idle_inc", int'(dut4.inc_reg), IDLEI);
    check_eq("b4_valid", int'(dv4), 1);
    check_eq("b4_peak", (data4 >= -14'sd8191) ? 1 : 0, 1);

    // Reset 100 cycles into a byte
    send_byte(8'h3C);
    s_tvalid = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    #1;
    check_eq("midrst_data_out", int'(data_out), 0);
    check_eq("midrst_data_valid", int'(data_valid), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_inc", int'(dut.inc_reg), IDLEI);
    repeat (3) step();
    rst = 1'b0;
    repeat (600) step();
    check_eq("post_rst_busy", int'(busy), 0);
    check_eq("post_rst_inc", int'(dut.inc_reg), IDLEI);
    check_eq("scoreboard_empty", sb.size() + sb4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
